amba_sram_bridge: RTL and testbench

AMBA_SRAM_BRIDGE -- requirements
Module: amba_sram_bridge

---
 rtl/amba_sram_bridge.sv | 158 +++++++++++++++
 tb/tb_amba_sram_bridge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/amba_sram_bridge.sv
// Command-to-SRAM bridge: sequences single-beat key/data writes and data reads with registered strobes.
// Optional macro AMBA_BURST_EN enables multi-slot bursts from cmd_slot up to NUM_SLOTS-1.
module amba_sram_bridge #(
  parameter int DATA_W      = 128,
  parameter int ADDR_W      = 16,
  parameter int NUM_SLOTS   = 4,
  parameter int DATA_BASE   = 32,
  parameter int SLOT_STRIDE = 16,
  parameter int RD_LAT      = 1,
  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [SLOT_W-1:0] cmd_slot,
  input  logic              cmd_burst,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] HRDATA,
  output logic              rdata_valid,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data
);

  // state  | meaning
  // IDLE   | ready, accepting commands
  // SETUP  | address/data presented, no strobe
  // ACCESS | one-cycle read or write strobe
  // WAIT   | read latency beyond the first cycle
  // RESP   | read word captured, rdata_valid pulse
  // ERR1   | error response, not ready
  // ERR2   | error response, ready
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT, RESP, ERR1, ERR2} state_t;

`ifdef AMBA_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              rd_q, rd_d, key_q, key_d, burst_q, burst_d, load;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [2:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              bad_cmd;

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] s);
    logic [31:0] a;
    a = 32'(DATA_BASE) + 32'(s) * 32'(SLOT_STRIDE);
    return a[ADDR_W-1:0];
  endfunction

  assign bad_cmd = (cmd_op == 2'b11) ||
                   ((cmd_op != 2'b00) && ({1'b0, cmd_slot} >= (SLOT_W+1)'(NUM_SLOTS)));

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    key_d   = key_q;
    burst_d = burst_q;
    slot_d  = slot_q;
    wait_d  = wait_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        if (bad_cmd) state_d = ERR1;
        else begin
          state_d = SETUP;
          rd_d    = (cmd_op == 2'b10);
          key_d   = (cmd_op == 2'b00);
          slot_d  = (cmd_op == 2'b00) ? '0 : cmd_slot;
          burst_d = BURST_EN && cmd_burst && (cmd_op != 2'b00);
          load    = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (rd_q) begin
          if (RD_LAT <= 1) state_d = RESP;
          else begin
            state_d = WAIT;
            wait_d  = 3'(RD_LAT - 2);
          end
        end else if (burst_q && slot_q != SLOT_W'(NUM_SLOTS - 1)) begin
          state_d = SETUP;
          slot_d  = SLOT_W'(slot_q + 1'b1);
          load    = 1'b1;
        end else state_d = IDLE;
      end
      WAIT: begin
        if (wait_q == 3'd0) state_d = RESP;
        else wait_d = wait_q - 3'd1;
      end
      RESP: begin
        if (burst_q && slot_q != SLOT_W'(NUM_SLOTS - 1)) begin
          state_d = SETUP;
          slot_d  = SLOT_W'(slot_q + 1'b1);
          load    = 1'b1;
        end else state_d = IDLE;
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and write payload are latched on every entry to SETUP, so bursts re-sample HWDATA.
  always_comb begin
    addr_d  = addr;
    wdata_d = write_data;
    if (load) begin
      addr_d = key_d ? '0 : slot_addr(slot_d);
      if (!rd_d) wdata_d = HWDATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      key_q       <= 1'b0;
      burst_q     <= 1'b0;
      slot_q      <= '0;
      wait_q      <= 3'd0;
      HRDATA      <= '0;
      write_data  <= '0;
      addr        <= '0;
      read        <= 1'b0;
      write       <= 1'b0;
      rdata_valid <= 1'b0;
      HRESP       <= 1'b0;
      HREADYOUT   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      key_q       <= key_d;
      burst_q     <= burst_d;
      slot_q      <= slot_d;
      wait_q      <= wait_d;
      addr        <= addr_d;
      write_data  <= wdata_d;
      read        <= (state_d == ACCESS) && rd_d;
      write       <= (state_d == ACCESS) && !rd_d;
      rdata_valid <= (state_d == RESP);
      if (state_d == RESP) HRDATA <= read_data;
      HRESP       <= (state_d == ERR1) || (state_d == ERR2);
      HREADYOUT   <= (state_d == IDLE) || (state_d == ERR2);
    end
  end

endmodule

// File: tb/tb_amba_sram_bridge.sv
// Directed bench for amba_sram_bridge (RD_LAT=3); burst steps depend on AMBA_BURST_EN.
module tb_amba_sram_bridge;

  localparam int DATA_W = 128;
  localparam int SLOT_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [SLOT_W-1:0] cmd_slot;
  logic              cmd_burst;
  logic [DATA_W-1:0] HWDATA, read_data, HRDATA, write_data;
  logic              rdata_valid, HREADYOUT, HRESP, read, write;
  logic [15:0]       addr;

  int checks = 0;
  int failures = 0;

  localparam logic [DATA_W-1:0] PAT_A5 = {16{8'hA5}};

  amba_sram_bridge #(.RD_LAT(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_slot(cmd_slot),
    .cmd_burst(cmd_burst), .HWDATA(HWDATA), .read_data(read_data), .HRDATA(HRDATA),
    .rdata_valid(rdata_valid), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .read(read),
    .write(write), .addr(addr), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_slot = '0; cmd_burst = 1'b0;
    HWDATA = '0; read_data = '0;
    step(); step();
    chk("rst_hready", HREADYOUT, 0);
    chk("rst_hresp", HRESP, 0);
    chk("rst_rw", {read, write}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_rvalid", rdata_valid, 0);
    rst = 1'b0;
    step();
    chk("post_rst_hready", HREADYOUT, 1);

    // write slot 2; a stray reserved command while busy must be ignored
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_slot = 2'd2; HWDATA = PAT_A5;
    step();
    cmd_op = 2'b11; HWDATA = 128'h1;
    chk("wr_setup_write", write, 0);
    chk("wr_setup_addr", addr, 64);
    chk("wr_setup_wdata", write_data, PAT_A5);
    chk("wr_setup_hready", HREADYOUT, 0);
    step();
    chk("wr_access_write", write, 1);
    chk("wr_access_read", read, 0);
    chk("wr_access_addr", addr, 64);
    chk("wr_access_wdata", write_data, PAT_A5);
    cmd_valid = 1'b0;
    step();
    chk("wr_done_write", write, 0);
    chk("wr_done_hready", HREADYOUT, 1);
    chk("wr_busy_ignored_hresp", HRESP, 0);
    step();
    chk("idle_hresp", HRESP, 0);
    chk("idle_write", write, 0);

    // read slot 1 with RD_LAT=3
    read_data = 128'h1234;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_slot = 2'd1;
    step();
    cmd_valid = 1'b0;
    chk("rd_setup_read", read, 0);
    chk("rd_setup_addr", addr, 48);
    step();
    chk("rd_access_read", read, 1);
    chk("rd_access_write", write, 0);
    chk("rd_access_addr", addr, 48);
    step();
    chk("rd_wait1", {read, rdata_valid}, 0);
    step();
    chk("rd_wait2", {read, rdata_valid}, 0);
    step();
    chk("rd_resp_valid", rdata_valid, 1);
    chk("rd_resp_data", HRDATA, 128'h1234);
    chk("rd_resp_hready", HREADYOUT, 0);
    read_data = 128'hDEAD;
    step();
    chk("rd_done_valid", rdata_valid, 0);
    chk("rd_hold_data", HRDATA, 128'h1234);
    chk("rd_done_hready", HREADYOUT, 1);

    // reserved op
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_slot = 2'd0;
    step();
    cmd_valid = 1'b0;
    chk("err1_hresp", HRESP, 1);
    chk("err1_hready", HREADYOUT, 0);
    chk("err1_rw", {read, write}, 0);
    step();
    chk("err2_hresp", HRESP, 1);
    chk("err2_hready", HREADYOUT, 1);
    chk("err2_rw", {read, write}, 0);
    step();
    chk("err_done_hresp", HRESP, 0);
    chk("err_done_hready", HREADYOUT, 1);

    // key write ignores slot and targets address 0
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_slot = 2'd3; HWDATA = 128'h55;
    step();
    cmd_valid = 1'b0;
    chk("key_setup_addr", addr, 0);
    chk("key_setup_wdata", write_data, 128'h55);
    step();
    chk("key_access_write", write, 1);
    chk("key_access_addr", addr, 0);
    step();
    chk("key_done_hready", HREADYOUT, 1);

    // reset during SETUP of a write aborts it
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_slot = 2'd3; HWDATA = 128'h77;
    step();
    cmd_valid = 1'b0;
    chk("abort_setup_addr", addr, 80);
    rst = 1'b1;
    step();
    chk("abort_rst_write", write, 0);
    chk("abort_rst_addr", addr, 0);
    chk("abort_rst_hready", HREADYOUT, 0);
    rst = 1'b0;
    step();
    chk("abort_idle_write", write, 0);
    chk("abort_idle_hready", HREADYOUT, 1);
    step();
    chk("abort_late_write", write, 0);
    chk("abort_late_hready", HREADYOUT, 1);

    // burst read from slot 2
    read_data = 128'hBEEF;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_slot = 2'd2; cmd_burst = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_burst = 1'b0;
    chk("bst_setup0_addr", addr, 64);
    step();
    chk("bst_access0_read", read, 1);
    step(); step(); step();
    chk("bst_resp0_valid", rdata_valid, 1);
    chk("bst_resp0_data", HRDATA, 128'hBEEF);
    read_data = 128'hCAFE;
    step();
`ifdef AMBA_BURST_EN
    chk("bst_setup1_addr", addr, 80);
    chk("bst_setup1_valid", rdata_valid, 0);
    chk("bst_setup1_hready", HREADYOUT, 0);
    step();
    chk("bst_access1_read", read, 1);
    chk("bst_access1_addr", addr, 80);
    step(); step(); step();
    chk("bst_resp1_valid", rdata_valid, 1);
    chk("bst_resp1_data", HRDATA, 128'hCAFE);
    step();
    chk("bst_done_hready", HREADYOUT, 1);
    chk("bst_done_valid", rdata_valid, 0);
`else
    chk("nobst_done_hready", HREADYOUT, 1);
    step();
    chk("nobst_no_read", read, 0);
    chk("nobst_addr_held", addr, 64);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
